// File: rtl/addr_gen_bkt_head_pkg.sv
// Shared geometry for the path-walk bucket index generator.
// Holds DRAM burst/row constants, the bucket-size functions and the
// subtree-height helpers used to pack buckets into DRAM rows.
package addr_gen_bkt_head_pkg;

  localparam int DDRBstLen    = 8;                      // beats per burst
  localparam int DDRDWidth    = 64;                     // DQ bits per beat
  localparam int DDRBurstBits = DDRBstLen * DDRDWidth;  // bits per burst
  localparam int DDRRowBursts = 16;                     // bursts per DRAM row

  // Header: optional IV plus per-block valid bit, program address and leaf,
  // rounded up to whole encryption chunks, then to whole bursts.
  function automatic int bkt_hsize_drbursts(int B, int U, int L, int Z,
                                            int BED, int IV);
    int hbits;
    hbits = ((IV != 0) ? BED : 0) + Z * (1 + U + L);
    if (BED > 0) hbits = ((hbits + BED - 1) / BED) * BED;
    if (B < 0) hbits = 0;  // B never negative; keeps argument lists uniform
    return (hbits + DDRBurstBits - 1) / DDRBurstBits;
  endfunction

  // Whole bucket: header bursts plus Z data blocks.
  function automatic int bkt_size_drbursts(int B, int U, int L, int Z,
                                           int BED, int IV);
    return bkt_hsize_drbursts(B, U, L, Z, BED, IV) +
           (Z * B + DDRBurstBits - 1) / DDRBurstBits;
  endfunction

  // Subtree height h = max(1, floor(log2(rowbursts/bktsize + 1))).
  function automatic int st_levels(int bkt_bursts);
    int v;
    int lg;
    v  = DDRRowBursts / ((bkt_bursts > 0) ? bkt_bursts : 1) + 1;
    lg = $clog2(v + 1) - 1;
    return (lg < 1) ? 1 : lg;
  endfunction

  // Root subtree takes the leftover levels: r = (L mod h) + 1.
  function automatic int root_levels(int L, int h);
    return (L % h) + 1;
  endfunction

  // Width of the level counter; must hold L+1 (the idle marker).
  function automatic int lvl_width(int L);
    return $clog2(L) + 1;
  endfunction

  localparam int BktSize_DRBursts  = bkt_size_drbursts(512, 32, 10, 5, 64, 1);
  localparam int BktHSize_DRBursts = bkt_hsize_drbursts(512, 32, 10, 5, 64, 1);
  localparam int STLevels          = st_levels(BktSize_DRBursts);
  localparam int RootLevels        = root_levels(10, STLevels);

endpackage

// File: rtl/addr_gen_bkt_head_if.sv
// Bundle of the walk control pulses and the per-level index outputs.
// Start and Enable are single-cycle pulses sampled on the rising clock edge
// (no ready back-pressure): Start latches leaf and restarts at the root,
// Enable advances one level; outputs are registered and show the result on
// the cycle after the pulse.
interface addr_gen_bkt_head_if
  import addr_gen_bkt_head_pkg::*;
#(
  parameter int ORAML = 10
) ();
  localparam int ORAMLogL = lvl_width(ORAML);

  logic                Start;
  logic                Enable;
  logic [ORAML-1:0]    leaf;
  logic [ORAMLogL-1:0] currentLevel;
  logic [ORAML+1:0]    BktIdx;
  logic [ORAML:0]      STIdx;
  logic [ORAML:0]      BktIdxInST;
  logic [ORAML:0]      BktID;

  modport master (
    output Start, Enable, leaf,
    input  currentLevel, BktIdx, STIdx, BktIdxInST, BktID
  );

  modport slave (
    input  Start, Enable, leaf,
    output currentLevel, BktIdx, STIdx, BktIdxInST, BktID
  );
endinterface

// File: rtl/addr_gen_bkt_head_bkt_id_gen.sv
// Logical (heap-numbered) bucket ID tracker along the same root-to-leaf path.
// Stops advancing after ORAML steps so stray Enables never overflow the ID.
module addr_gen_bkt_head_bkt_id_gen
  import addr_gen_bkt_head_pkg::*;
#(
  parameter int ORAML = 10
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReStart,
  input  logic             Enable,
  input  logic [ORAML-1:0] leaf,
  output logic [ORAML:0]   BktID
);
  localparam int LW = lvl_width(ORAML);
  localparam logic [LW-1:0] CNT_DONE = LW'(ORAML);

  logic [ORAML:0]   r_id;
  logic [ORAML-1:0] r_leaf_sh;
  logic [LW-1:0]    r_cnt;
  logic [ORAML:0]   w_bext;

  // Current path bit widened to the ID width.
  always_comb begin
    w_bext = {{ORAML{1'b0}}, r_leaf_sh[0]};
  end

  // Heap walk: restart at ID 0, each step moves to child 2*ID+1+bit.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_id      <= '0;
      r_leaf_sh <= '0;
      r_cnt     <= CNT_DONE;
    end else if (ReStart) begin
      r_id      <= '0;
      r_leaf_sh <= leaf;
      r_cnt     <= '0;
    end else if (Enable && (r_cnt < CNT_DONE)) begin
      r_id      <= (r_id << 1) + {{ORAML{1'b0}}, 1'b1} + w_bext;
      r_leaf_sh <= r_leaf_sh >> 1;
      r_cnt     <= r_cnt + LW'(1);
    end
  end

  assign BktID = r_id;
endmodule

// File: rtl/addr_gen_bkt_head.sv
// Path-walk bucket index generator: steps from the root toward the latched
// leaf and reports the subtree-packed physical slot of each visited bucket.
// Lower subtrees hold 2^h-1 buckets in 2^h slots; the root subtree is r tall.
module addr_gen_bkt_head
  import addr_gen_bkt_head_pkg::*;
#(
  parameter int ORAMB         = 512,
  parameter int ORAMU         = 32,
  parameter int ORAML         = 10,
  parameter int ORAMZ         = 5,
  parameter int BEDWidth      = 64,
  parameter int EnableIV      = 1,
  parameter int STLevelsForce = 0   // nonzero overrides the derived subtree height
) (
  input  logic          Clock,
  input  logic          Reset,
  addr_gen_bkt_head_if.slave bus
);
  localparam int BKT = bkt_size_drbursts(ORAMB, ORAMU, ORAML, ORAMZ,
                                         BEDWidth, EnableIV);
  localparam int H   = (STLevelsForce > 0) ? STLevelsForce : st_levels(BKT);
  localparam int R   = root_levels(ORAML, H);
  localparam int LW  = lvl_width(ORAML);
  localparam int NW  = ORAML + 1;

  localparam logic [LW-1:0] LVL_DONE   = LW'(ORAML + 1);
  localparam logic [LW-1:0] LVL_LAST   = LW'(ORAML);
  localparam logic [LW-1:0] ROOT_LLAST = LW'(R - 1);
  localparam logic [LW-1:0] ST_LLAST   = LW'(H - 1);
  localparam logic [NW-1:0] ROOT_BASE  = NW'((1 << (R - 1)) - 1);
  localparam logic [NW-1:0] ST_BASE    = NW'((1 << (H - 1)) - 1);
  localparam logic [NW-1:0] ONE        = NW'(1);
  localparam logic [NW-1:0] ROOT_OFS   = NW'(1 + (1 << R));

  logic [LW-1:0]    r_level;
  logic [LW-1:0]    r_lvl_in_st;
  logic [NW-1:0]    r_st_idx;
  logic [NW-1:0]    r_in_st;
  logic [ORAML-1:0] r_leaf_sh;

  logic [NW-1:0]    w_bext;
  logic             w_root;
  logic             w_cross;
  logic [NW-1:0]    w_pos;
  logic [NW-1:0]    w_st_next;
  logic [NW-1:0]    w_in_next;
  logic             w_active;
  logic             w_step;
  logic [NW:0]      w_bkt_idx;

  // Next-index math for one step; crossing happens at the last local level.
  always_comb begin
    w_bext    = {{ORAML{1'b0}}, r_leaf_sh[0]};
    w_root    = (r_st_idx == '0);
    w_cross   = (r_lvl_in_st == (w_root ? ROOT_LLAST : ST_LLAST));
    w_pos     = ((r_in_st - (w_root ? ROOT_BASE : ST_BASE)) << 1) + w_bext;
    w_st_next = w_root ? (ONE + w_pos)
                       : (ROOT_OFS + ((r_st_idx - ONE) << H) + w_pos);
    w_in_next = w_cross ? '0 : ((r_in_st << 1) + ONE + w_bext);
    w_active  = bus.Enable && (r_level <= LVL_LAST);
    w_step    = w_active && (r_level != LVL_LAST);
    w_bkt_idx = ({1'b0, r_st_idx} << H) + {1'b0, r_in_st};
  end

  // Walk state: reset > start > enable; the final enable only goes idle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_level     <= LVL_DONE;
      r_lvl_in_st <= '0;
      r_st_idx    <= '0;
      r_in_st     <= '0;
      r_leaf_sh   <= '0;
    end else if (bus.Start) begin
      r_level     <= '0;
      r_lvl_in_st <= '0;
      r_st_idx    <= '0;
      r_in_st     <= '0;
      r_leaf_sh   <= bus.leaf;
    end else if (w_active) begin
      r_level <= r_level + LW'(1);
      if (w_step) begin
        r_leaf_sh   <= r_leaf_sh >> 1;
        r_in_st     <= w_in_next;
        r_st_idx    <= w_cross ? w_st_next : r_st_idx;
        r_lvl_in_st <= w_cross ? '0 : (r_lvl_in_st + LW'(1));
      end
    end
  end

  addr_gen_bkt_head_bkt_id_gen #(
    .ORAML(ORAML)
  ) u_bkt_id_gen (
    .Clock  (Clock),
    .Reset  (Reset),
    .ReStart(bus.Start),
    .Enable (bus.Enable),
    .leaf   (bus.leaf),
    .BktID  (bus.BktID)
  );

  assign bus.currentLevel = r_level;
  assign bus.STIdx        = r_st_idx;
  assign bus.BktIdxInST   = r_in_st;
  assign bus.BktIdx       = w_bkt_idx;
endmodule

// File: tb/tb_addr_gen_bkt_head.sv
// Directed bench for addr_gen_bkt_head with ORAML=3 and subtree height 2.
// Driver pushes the expected post-edge outputs; a negedge monitor pops them.
module tb_addr_gen_bkt_head;
  localparam int L = 3;

  logic clk;
  logic rst;
  logic obs_pend;
  logic armed;
  logic done;
  logic reported;
  int   n_checks;
  int   n_err;

  // {level[2:0], bkt[4:0], st[3:0], in_st[3:0], id[3:0]}
  logic [19:0] exp_q[$];

  addr_gen_bkt_head_if #(.ORAML(L)) bus ();

  addr_gen_bkt_head #(
    .ORAML(L),
    .STLevelsForce(2)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, required reaching summary");
    $fatal(1);
  end

  // Driver: apply inputs for one edge and queue the outputs expected after it.
  task automatic step(input logic r, input logic s, input logic e,
                      input logic [2:0] lf, input int lvl, input int bkt,
                      input int st, input int in_st, input int id);
    rst        = r;
    bus.Start  = s;
    bus.Enable = e;
    bus.leaf   = lf;
    exp_q.push_back({3'(lvl), 5'(bkt), 4'(st), 4'(in_st), 4'(id)});
    obs_pend   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard comparison.
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) armed <= obs_pend;

  // Monitor: compare outputs on the negedge after each driven edge.
  always @(negedge clk) begin
    logic [19:0] e;
    if (armed) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL underflow: got output with 0 expected entries");
      end else begin
        e = exp_q.pop_front();
        chk("currentLevel", int'(bus.currentLevel), int'(e[19:17]));
        chk("BktIdx",       int'(bus.BktIdx),       int'(e[16:12]));
        chk("STIdx",        int'(bus.STIdx),        int'(e[11:8]));
        chk("BktIdxInST",   int'(bus.BktIdxInST),   int'(e[7:4]));
        chk("BktID",        int'(bus.BktID),        int'(e[3:0]));
      end
    end else if (done && !reported) begin
      reported <= 1'b1;
      chk("leftover", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
    end
  end

  // Stimulus.
  initial begin
    n_checks   = 0;
    n_err      = 0;
    armed      = 1'b0;
    done       = 1'b0;
    reported   = 1'b0;
    obs_pend   = 1'b0;
    rst        = 1'b1;
    bus.Start  = 1'b0;
    bus.Enable = 1'b0;
    bus.leaf   = '0;
    @(posedge clk);
    #1;
    // reset state, then enables while idle are ignored
    step(1, 0, 0, 3'b000, 4, 0, 0, 0, 0);
    step(1, 0, 0, 3'b000, 4, 0, 0, 0, 0);
    step(0, 0, 1, 3'b000, 4, 0, 0, 0, 0);
    step(0, 0, 1, 3'b111, 4, 0, 0, 0, 0);
    // leaf 101, enable held: BktIdx 0,2,12,14 then idle
    step(0, 1, 0, 3'b101, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3'b000, 1, 2, 0, 2, 2);
    step(0, 0, 1, 3'b000, 2, 12, 3, 0, 5);
    step(0, 0, 1, 3'b000, 3, 14, 3, 2, 12);
    step(0, 0, 1, 3'b000, 4, 14, 3, 2, 12);
    step(0, 0, 1, 3'b000, 4, 14, 3, 2, 12);
    // leaf 000: BktIdx 0,1,4,5
    step(0, 1, 0, 3'b000, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3'b000, 1, 1, 0, 1, 1);
    step(0, 0, 1, 3'b000, 2, 4, 1, 0, 3);
    step(0, 0, 0, 3'b000, 2, 4, 1, 0, 3);
    step(0, 0, 1, 3'b000, 3, 5, 1, 1, 7);
    step(0, 0, 1, 3'b000, 4, 5, 1, 1, 7);
    // leaf 111: BktIdx 0,2,16,18
    step(0, 1, 0, 3'b111, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3'b000, 1, 2, 0, 2, 2);
    step(0, 0, 1, 3'b000, 2, 16, 4, 0, 6);
    step(0, 0, 1, 3'b000, 3, 18, 4, 2, 14);
    step(0, 0, 1, 3'b000, 4, 18, 4, 2, 14);
    // restart at level 2 (with Enable also high) using leaf 000
    step(0, 1, 0, 3'b101, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3'b000, 1, 2, 0, 2, 2);
    step(0, 0, 1, 3'b000, 2, 12, 3, 0, 5);
    step(0, 1, 1, 3'b000, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3'b111, 1, 1, 0, 1, 1);
    step(0, 0, 1, 3'b111, 2, 4, 1, 0, 3);
    step(0, 0, 1, 3'b111, 3, 5, 1, 1, 7);
    step(0, 0, 1, 3'b111, 4, 5, 1, 1, 7);
    // reset at level 1 together with Enable
    step(0, 1, 0, 3'b111, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3'b000, 1, 2, 0, 2, 2);
    step(1, 0, 1, 3'b000, 4, 0, 0, 0, 0);
    step(0, 0, 1, 3'b000, 4, 0, 0, 0, 0);
    obs_pend   = 1'b0;
    rst        = 1'b0;
    bus.Start  = 1'b0;
    bus.Enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    done = 1'b1;
  end
endmodule
